// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared encodings and pipeline register layouts for the memory stage
package mem_stage_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_e;

    // Funct3[1:0] selects the access size, Funct3[2] selects zero-extension
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam int         F3_UNSIGNED_BIT = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] store_data;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_write;
        result_src_e result_src;
        logic [2:0]  funct3;
    } exmem_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        reg_write;
        logic        fault;
    } memwb_t;

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane store alignment and load extract/extend; MEM_MISALIGN_CHK_EN flags misaligned H/W accesses
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        is_signed;

    always_comb begin
        is_signed = ~funct3[F3_UNSIGNED_BIT];
        byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        case (funct3[1:0])
            SZ_B: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{is_signed & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
`ifdef MEM_MISALIGN_CHK_EN
        case (funct3[1:0])
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = addr_lo[0];
            default: misaligned = (addr_lo != 2'b00);
        endcase
`else
        misaligned = 1'b0;
`endif
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX/MEM register, data-memory request FSM, MEM/WB register and writeback mux; MEM_MISALIGN_CHK_EN enables misalignment faults
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [31:0] PCplus4E,
    input  logic [4:0]  RdE,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic [1:0]  ResultSrcE,
    input  logic [2:0]  Funct3E,
    input  logic        flushM,
    output logic        dmem_valid,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_err,
    output logic        stallM,
    output logic [31:0] ALUResultM,
    output logic [4:0]  RdM,
    output logic        RegWriteM,
    output logic [31:0] ResultW,
    output logic [4:0]  RdW,
    output logic        RegWriteW,
    output logic        faultW
);

    exmem_t        exmem_q, exmem_d;
    memwb_t        memwb_q, memwb_d;
    mem_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic        misaligned;
    logic        memop, req, at_limit, timeout, fault, stall;

    mem_align u_align (
        .funct3     (exmem_q.funct3),
        .addr_lo    (exmem_q.alu[1:0]),
        .store_data (exmem_q.store_data),
        .rdata      (dmem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    // cnt counts cycles the current request has been waiting, including the first
    always_comb begin
        memop    = exmem_q.mem_write | (exmem_q.result_src == RES_LOAD);
        req      = memop & ~misaligned;
        at_limit = (state_q == ST_WAIT) && (cnt_q == CW'(TIMEOUT - 1));
        timeout  = req & ~dmem_ready & at_limit;
        stall    = req & ~dmem_ready & ~at_limit;
        fault    = (memop & misaligned) | (req & dmem_ready & dmem_err) | timeout;
    end

    always_comb begin
        exmem_d = exmem_q;
        if (flushM) begin
            exmem_d = '0;
        end else if (!stall) begin
            exmem_d.alu        = ALUResultE;
            exmem_d.store_data = WriteDataE;
            exmem_d.pc4        = PCplus4E;
            exmem_d.rd         = RdE;
            exmem_d.reg_write  = RegWriteE;
            exmem_d.mem_write  = MemWriteE;
            exmem_d.result_src = result_src_e'(ResultSrcE);
            exmem_d.funct3     = Funct3E;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (!flushM && stall) begin
            state_d = ST_WAIT;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // A stalled cycle retires a bubble; a faulting access never writes back
    always_comb begin
        memwb_d = '0;
        if (!stall) begin
            memwb_d.rd        = exmem_q.rd;
            memwb_d.fault     = fault;
            memwb_d.reg_write = exmem_q.reg_write & ~fault;
            if (!fault) begin
                case (exmem_q.result_src)
                    RES_LOAD: memwb_d.result = load_data;
                    RES_PC4:  memwb_d.result = exmem_q.pc4;
                    default:  memwb_d.result = exmem_q.alu;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exmem_q <= '0;
            memwb_q <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stallM     = stall;
    assign dmem_valid = req;
    assign dmem_we    = req & exmem_q.mem_write;
    assign dmem_addr  = {exmem_q.alu[31:2], 2'b00};
    assign dmem_wdata = lane_wdata;
    assign dmem_be    = req ? lane_be : 4'b0000;
    assign ALUResultM = exmem_q.alu;
    assign RdM        = exmem_q.rd;
    assign RegWriteM  = exmem_q.reg_write;
    assign ResultW    = memwb_q.result;
    assign RdW        = memwb_q.rd;
    assign RegWriteW  = memwb_q.reg_write;
    assign faultW     = memwb_q.fault;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage against an instruction-level model
module tb_mem_stage;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ALUResultE, WriteDataE, PCplus4E;
    logic [4:0]  RdE;
    logic        RegWriteE, MemWriteE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  Funct3E;
    logic        flushM;
    logic        dmem_valid, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        dmem_err;
    logic        stallM;
    logic [31:0] ALUResultM;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic [31:0] ResultW;
    logic [4:0]  RdW;
    logic        RegWriteW, faultW;

    mem_stage #(.TIMEOUT(TIMEOUT), .CW(5)) dut (
        .clk(clk), .reset(reset),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCplus4E(PCplus4E),
        .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .Funct3E(Funct3E), .flushM(flushM),
        .dmem_valid(dmem_valid), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .dmem_err(dmem_err), .stallM(stallM),
        .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
        .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW), .faultW(faultW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  rs;
        logic        mw, rw;
        logic [4:0]  rd;
        logic [31:0] addr, rs2, pc4, rdata;
        logic        err;
        int          delay, flush_k, rst_k;
    } op_t;

    typedef struct {
        logic [3:0]  be;
        logic [31:0] wdata, load;
        logic        mis;
    } pred_t;

    int n_checks = 0;
    int n_errors = 0;

    logic        chk_en = 1'b0;
    logic        e_zero, e_stall, e_valid, e_we, e_rwm, e_bubble, e_rw, e_fault;
    logic [31:0] e_addr, e_wdata, e_alum, e_res;
    logic [3:0]  e_be;
    logic [4:0]  e_rdm, e_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Access as a run of nb bytes starting at the size-aligned offset
    function automatic pred_t predict(input op_t op);
        pred_t p;
        int nb, start, a;
        a     = int'(op.addr[1:0]);
        nb    = (op.f3[1:0] == 2'b00) ? 1 : (op.f3[1:0] == 2'b01) ? 2 : 4;
        start = (a / nb) * nb;
        p.be = '0; p.wdata = '0; p.load = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= start && i < start + nb) p.be[i] = 1'b1;
            p.wdata[8*i +: 8] = op.rs2[8*(i % nb) +: 8];
        end
        for (int j = 0; j < nb; j++) p.load[8*j +: 8] = op.rdata[8*(start + j) +: 8];
        if (!op.f3[2] && nb < 4 && p.load[8*nb-1]) p.load = p.load | (32'hFFFFFFFF << (8*nb));
`ifdef MEM_MISALIGN_CHK_EN
        p.mis = (start != a);
`else
        p.mis = 1'b0;
`endif
        return p;
    endfunction

    function automatic op_t mk(input logic [2:0] f3, input logic [1:0] rs, input logic mw,
                               input logic rw, input logic [4:0] rd, input logic [31:0] addr,
                               input logic [31:0] rs2, input logic [31:0] rdata,
                               input logic err, input int delay);
        op_t o;
        o.f3 = f3; o.rs = rs; o.mw = mw; o.rw = rw; o.rd = rd; o.addr = addr;
        o.rs2 = rs2; o.pc4 = 32'h0000_1004; o.rdata = rdata; o.err = err;
        o.delay = delay; o.flush_k = -1; o.rst_k = -1;
        return o;
    endfunction

    task automatic clear_e();
        ALUResultE = '0; WriteDataE = '0; PCplus4E = '0; RdE = '0;
        RegWriteE = 1'b0; MemWriteE = 1'b0; ResultSrcE = '0; Funct3E = '0;
    endtask

    task automatic idle_expect();
        e_zero = 1'b0; e_stall = 1'b0; e_valid = 1'b0; e_we = 1'b0;
        e_alum = '0; e_rdm = '0; e_rwm = 1'b0; e_addr = '0; e_be = '0; e_wdata = '0;
        e_bubble = 1'b0; e_rw = 1'b0; e_fault = 1'b0; e_res = '0; e_rd = '0;
    endtask

    task automatic issue(input op_t op);
        pred_t p;
        logic  req, rdy, to, flt, stl;
        p   = predict(op);
        req = (op.mw || op.rs == 2'b01) && !p.mis;
        @(negedge clk);
        ALUResultE = op.addr; WriteDataE = op.rs2; PCplus4E = op.pc4; RdE = op.rd;
        RegWriteE = op.rw; MemWriteE = op.mw; ResultSrcE = op.rs; Funct3E = op.f3;
        flushM = 1'b0; dmem_ready = 1'b0; dmem_err = 1'b0; dmem_rdata = 32'hA5A5A5A5;
        idle_expect();
        for (int k = 0; k <= TIMEOUT; k++) begin
            @(negedge clk);
            clear_e();
            rdy = (k == op.delay);
            to  = req && !rdy && (k == TIMEOUT - 1);
            stl = req && !rdy && !to;
            flt = p.mis || (req && rdy && op.err) || to;
            dmem_ready = rdy;
            dmem_err   = rdy && op.err;
            dmem_rdata = rdy ? op.rdata : 32'hA5A5A5A5;
            flushM     = (k == op.flush_k);
            e_zero = 1'b0; e_stall = stl; e_valid = req; e_we = req && op.mw;
            e_addr = {op.addr[31:2], 2'b00}; e_be = p.be; e_wdata = p.wdata;
            e_alum = op.addr; e_rdm = op.rd; e_rwm = op.rw;
            e_bubble = stl; e_rw = !stl && op.rw && !flt; e_fault = !stl && flt; e_rd = op.rd;
            e_res = (op.rs == 2'b01) ? p.load : (op.rs == 2'b10) ? op.pc4 : op.addr;
            if (k == op.rst_k) begin
                #1;
                reset = 1'b0;
                dmem_ready = 1'b0; dmem_err = 1'b0;
                idle_expect();
                e_zero = 1'b1;
                @(negedge clk);
                #1;
                reset = 1'b1;
                break;
            end
            if (!stl || flushM) break;
        end
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            #4;
            if (chk_en) begin
                check("stallM", 32'(stallM), 32'(e_stall));
                check("dmem_valid", 32'(dmem_valid), 32'(e_valid));
                check("ALUResultM", ALUResultM, e_alum);
                check("RdM", 32'(RdM), 32'(e_rdm));
                check("RegWriteM", 32'(RegWriteM), 32'(e_rwm));
                if (e_valid) begin
                    check("dmem_we", 32'(dmem_we), 32'(e_we));
                    check("dmem_addr", dmem_addr, e_addr);
                    check("dmem_be", 32'(dmem_be), 32'(e_be));
                    if (e_we) check("dmem_wdata", dmem_wdata, e_wdata);
                end
            end
            @(posedge clk);
            #1;
            if (chk_en) begin
                check("RegWriteW", 32'(RegWriteW), 32'(e_rw));
                check("faultW", 32'(faultW), 32'(e_fault));
                if (e_zero || (!e_bubble && !e_fault)) begin
                    check("ResultW", ResultW, e_res);
                    check("RdW", 32'(RdW), 32'(e_rd));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        op_t   o;
        pred_t p;
        clear_e();
        flushM = 1'b0; dmem_ready = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;

        p = predict(mk(3'b010, 2'b00, 1'b1, 1'b0, 5'd0, 32'h100, 32'hDEADBEEF, '0, 1'b0, 0));
        check("pin_sw_be", 32'(p.be), 32'h0000000F);
        check("pin_sw_wdata", p.wdata, 32'hDEADBEEF);
        p = predict(mk(3'b000, 2'b00, 1'b1, 1'b0, 5'd0, 32'h103, 32'h1234565A, '0, 1'b0, 0));
        check("pin_sb_be", 32'(p.be), 32'h00000008);
        check("pin_sb_wdata", p.wdata, 32'h5A5A5A5A);
        p = predict(mk(3'b000, 2'b01, 1'b0, 1'b1, 5'd5, 32'h103, '0, 32'h80123456, 1'b0, 0));
        check("pin_lb", p.load, 32'hFFFFFF80);
        p = predict(mk(3'b100, 2'b01, 1'b0, 1'b1, 5'd5, 32'h103, '0, 32'h80123456, 1'b0, 0));
        check("pin_lbu", p.load, 32'h00000080);
        p = predict(mk(3'b001, 2'b01, 1'b0, 1'b1, 5'd9, 32'h101, '0, 32'h12348001, 1'b0, 0));
`ifdef MEM_MISALIGN_CHK_EN
        check("pin_lh_mis", 32'(p.mis), 32'd1);
`else
        check("pin_lh_be", 32'(p.be), 32'h00000003);
        check("pin_lh_load", p.load, 32'hFFFF8001);
`endif

        @(negedge clk);
        idle_expect();
        e_zero = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b1;

        issue(mk(3'b010, 2'b00, 1'b1, 1'b0, 5'd0, 32'h100, 32'hDEADBEEF, '0, 1'b0, 0));
        issue(mk(3'b000, 2'b00, 1'b1, 1'b0, 5'd0, 32'h103, 32'h1234565A, '0, 1'b0, 0));
        issue(mk(3'b000, 2'b01, 1'b0, 1'b1, 5'd5, 32'h103, '0, 32'h80123456, 1'b0, 0));
        issue(mk(3'b100, 2'b01, 1'b0, 1'b1, 5'd6, 32'h103, '0, 32'h80123456, 1'b0, 0));
        issue(mk(3'b010, 2'b01, 1'b0, 1'b1, 5'd7, 32'h200, '0, 32'hCAFEF00D, 1'b0, 3));
        issue(mk(3'b010, 2'b01, 1'b0, 1'b1, 5'd8, 32'h204, '0, 32'h11111111, 1'b0, -1));
        o = mk(3'b010, 2'b01, 1'b0, 1'b1, 5'd10, 32'h208, '0, 32'h22222222, 1'b0, -1);
        o.flush_k = 2;
        issue(o);
        o = mk(3'b010, 2'b01, 1'b0, 1'b1, 5'd11, 32'h20C, '0, 32'h33333333, 1'b0, -1);
        o.rst_k = 2;
        issue(o);
        issue(mk(3'b001, 2'b01, 1'b0, 1'b1, 5'd9, 32'h101, '0, 32'h12348001, 1'b0, 0));
        issue(mk(3'b000, 2'b00, 1'b0, 1'b1, 5'd3, 32'h11112222, '0, '0, 1'b1, 0));
        issue(mk(3'b000, 2'b10, 1'b0, 1'b1, 5'd1, 32'h00000040, '0, '0, 1'b0, 0));
        issue(mk(3'b101, 2'b01, 1'b0, 1'b1, 5'd12, 32'h202, '0, 32'hBEEF1234, 1'b0, 1));
        issue(mk(3'b001, 2'b00, 1'b1, 1'b0, 5'd0, 32'h102, 32'h0000ABCD, '0, 1'b0, 0));
        issue(mk(3'b010, 2'b01, 1'b0, 1'b1, 5'd13, 32'h300, '0, 32'h44444444, 1'b1, 2));
        issue(mk(3'b010, 2'b01, 1'b0, 1'b1, 5'd14, 32'h304, '0, 32'h55555555, 1'b0, TIMEOUT - 1));
        issue(mk(3'b000, 2'b01, 1'b0, 1'b1, 5'd15, 32'h101, '0, 32'h00007F00, 1'b0, 0));

        @(negedge clk);
        clear_e();
        flushM = 1'b0; dmem_ready = 1'b0; dmem_err = 1'b0;
        idle_expect();
        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory stage directly downstream of the execute unit: EX/MEM pipeline register, load/store request FSM on a valid/ready data-memory port, byte-lane store/load alignment, and MEM/WB register with the writeback result mux. Supplies ALUResultM/RdM/RegWriteM for forwarding and ResultW back to execute, and raises stallM to the hazard unit while an access is outstanding.

Parameters:
TIMEOUT, 16, cycles a request may wait for dmem_ready before it is aborted as a fault (>=2).
CW, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low
ALUResultE  in  32  execute result / effective address
WriteDataE  in  32  forwarded rs2 value (store data)
PCplus4E  in  32  link value for JAL/JALR
RdE  in  5  destination register
RegWriteE  in  1  register write enable
MemWriteE  in  1  store
ResultSrcE  in  2  00 ALU, 01 load, 10 PC+4
Funct3E  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
flushM  in  1  synchronous clear of EX/MEM register
dmem_valid  out  1  request valid
dmem_we  out  1  1 store, 0 load
dmem_addr  out  32  word-aligned address ({ALUResultM[31:2],2'b00})
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_ready  in  1  request accepted/completed this cycle
dmem_rdata  in  32  load data, valid when dmem_ready && !dmem_we
dmem_err  in  1  bus error, valid with dmem_ready
stallM  out  1  hold EX/MEM and upstream stages
ALUResultM  out  32  forwarding value
RdM  out  5  forwarding tag
RegWriteM  out  1  forwarding enable
ResultW  out  32  registered writeback data
RdW  out  5  writeback destination
RegWriteW  out  1  writeback enable
faultW  out  1  access fault/timeout on retiring instruction

Behaviour:
- Reset (reset=0, async): EX/MEM and MEM/WB registers cleared; all outputs 0; FSM IDLE; counter 0.
- EX/MEM loads E inputs on each edge when stallM=0; holds when stallM=1; flushM=1 clears it (bubble, all controls 0) and overrides the hold; flush takes priority over stall and aborts any outstanding request (FSM to IDLE, dmem_valid drops next cycle).
- memop = MemWriteM | (ResultSrcM==01). dmem_valid = memop in IDLE or WAIT; address/data/be stable while valid.
- FSM IDLE: memop && dmem_ready -> complete in the same cycle, stallM=0. memop && !dmem_ready -> WAIT, stallM=1. WAIT: stallM = !dmem_ready && cnt!=TIMEOUT-1; on dmem_ready -> IDLE. cnt increments each WAIT cycle and is cleared on exit. On reaching TIMEOUT-1: abort, fault=1, -> IDLE, dmem_valid=0 the following cycle.
- Store: B: be=0001<<a[1:0], wdata={4{rs2[7:0]}}; H: be=0011<<{a[1],0}, wdata={2{rs2[15:0]}}; W: be=1111. Load: be by the same rule; rdata lane shifted by a[1:0], sign- or zero-extended per Funct3M.
- MEM/WB updates every edge: stallM=1 inserts a bubble (RegWriteW=0, faultW=0). ResultW = ALU, load data, or PC+4 per ResultSrcM; load latency: data on ResultW the cycle after dmem_ready.
- dmem_err or timeout: faultW=1, RegWriteW forced 0 for that instruction.

Optional Feature:
MEM_MISALIGN_CHK_EN: defined -> H with a[0]=1 or W with a[1:0]!=0 issues no request (dmem_valid=0, no stall), retires with faultW=1, RegWriteW=0. Undefined -> misaligned offset bits ignored (H uses a[1], W uses the whole word), no fault.

Decomposition:
Shared package: ResultSrc encodings, Funct3 size codes, FSM state enum. One sub-module, mem_align (combinational be/wdata generation and load extract/extend); reuse the existing flop primitives for the pipeline registers.

Test Plan:
- SW x=0xDEADBEEF at 0x100, ready same cycle -> be=1111, wdata=0xDEADBEEF, stallM never 1, RegWriteW=0.
- SB 0x5A at 0x103 -> be=1000, wdata=0x5A5A5A5A; then LB at 0x103 with rdata=0x80xxxxxx -> ResultW=0xFFFFFF80; LBU -> 0x00000080.
- LW with ready after 3 cycles -> stallM=1 for 3 cycles, EX/MEM held, 3 bubbles in W, ResultW=rdata one cycle after ready.
- Ready never asserted, TIMEOUT=16 -> stallM high 15 cycles, then faultW=1, RegWriteW=0, dmem_valid low.
- flushM during WAIT, and reset mid-WAIT -> dmem_valid drops, stallM=0, FSM IDLE, no writeback.
- LH at 0x101 -> faultW=1 with no request (macro defined); with macro undefined, be=0011 with no fault.
